// File: rtl/bird_io_pkg.sv
// Shared constants and types for the bird CPU memory/IO bridge.
// Defines the IO window map, the STATUS bit positions and the STATUS word layout.
package bird_io_pkg;

  localparam logic [11:0]  IO_BASE_DEFAULT  = 12'hF00;
  localparam int unsigned  TX_DEPTH_DEFAULT = 8;

  localparam logic [1:0] IO_OFF_TXDATA  = 2'd0;
  localparam logic [1:0] IO_OFF_RXDATA  = 2'd1;
  localparam logic [1:0] IO_OFF_STATUS  = 2'd2;
  localparam logic [1:0] IO_OFF_TXCOUNT = 2'd3;

  localparam int unsigned ST_RX_FULL  = 0;
  localparam int unsigned ST_TX_FULL  = 1;
  localparam int unsigned ST_TX_EMPTY = 2;
  localparam int unsigned ST_TX_OVF   = 3;
  localparam int unsigned ST_RX_OVR   = 4;

  typedef struct packed {
    logic [10:0] rsvd;
    logic        rx_ovr;
    logic        tx_ovf;
    logic        tx_empty;
    logic        tx_full;
    logic        rx_full;
  } status_t;

endpackage

// File: rtl/bird_sync_fifo.sv
// Single-clock FIFO with registered head (no fall-through) and occupancy count.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module bird_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bird_io_bridge.sv
// Bridge between the bird CPU bus and external async RAM plus a 4-word IO window
// (TX byte FIFO, RX holding register, sticky status). All accesses complete same cycle.
module bird_io_bridge
  import bird_io_pkg::*;
#(
  parameter logic [11:0] IO_BASE  = IO_BASE_DEFAULT,
  parameter int unsigned TX_DEPTH = TX_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_data_out,
  input  logic        cpu_memwt,
  output logic [15:0] cpu_data_in,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;

  logic [1:0]       off;
  logic             io_sel, io_wr, io_rd;
  logic             tx_push, tx_pop, tx_reject;
  logic             tx_full, tx_empty;
  logic [7:0]       tx_head;
  logic [TX_CW-1:0] tx_count;
  logic             rx_rd, rx_drop, st_wr;
  logic [7:0]       rx_hold;
  logic             rx_full, tx_ovf, rx_ovr;
  status_t          status;
  logic [15:0]      io_rdata;
  logic             unused_addr_hi;

  // Address bits above the 4K space only alias.
  assign unused_addr_hi = ^cpu_address[15:12];

  assign off     = cpu_address[1:0];
  assign io_sel  = (cpu_address[11:2] == IO_BASE[11:2]);
  assign io_wr   = io_sel & cpu_memwt;
  assign io_rd   = io_sel & ~cpu_memwt;

  assign tx_push   = io_wr & (off == IO_OFF_TXDATA);
  assign st_wr     = io_wr & (off == IO_OFF_STATUS);
  assign rx_rd     = io_rd & (off == IO_OFF_RXDATA);
  assign tx_pop    = tx_valid & tx_ready;
  assign tx_reject = tx_push & tx_full & ~tx_pop;
  assign rx_drop   = rx_valid & rx_full & ~rx_rd;

  assign mem_addr  = cpu_address[11:0];
  assign mem_wdata = cpu_data_out;
  assign mem_we    = cpu_memwt & ~io_sel & ~rst;

  assign tx_valid  = ~tx_empty;
  assign tx_data   = tx_empty ? 8'h00 : tx_head;

  bird_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (cpu_data_out[7:0]),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // RX holding register and sticky flags; a new overflow beats a same-cycle W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_hold <= 8'h00;
      rx_full <= 1'b0;
      tx_ovf  <= 1'b0;
      rx_ovr  <= 1'b0;
    end else begin
      if (rx_valid && (!rx_full || rx_rd)) begin
        rx_hold <= rx_data;
        rx_full <= 1'b1;
      end else if (rx_rd) begin
        rx_full <= 1'b0;
      end

      if (tx_reject)                          tx_ovf <= 1'b1;
      else if (st_wr && cpu_data_out[ST_TX_OVF]) tx_ovf <= 1'b0;

      if (rx_drop)                            rx_ovr <= 1'b1;
      else if (st_wr && cpu_data_out[ST_RX_OVR]) rx_ovr <= 1'b0;
    end
  end

  // IO read mux and final CPU read steering.
  always_comb begin
    status          = '0;
    status.rx_full  = rx_full;
    status.tx_full  = tx_full;
    status.tx_empty = tx_empty;
    status.tx_ovf   = tx_ovf;
    status.rx_ovr   = rx_ovr;
    io_rdata        = 16'h0000;
    case (off)
      IO_OFF_RXDATA:  io_rdata = {8'h00, rx_hold};
      IO_OFF_STATUS:  io_rdata = 16'(status);
      IO_OFF_TXCOUNT: io_rdata = 16'(tx_count);
      default:        io_rdata = 16'h0000;
    endcase
  end

  assign cpu_data_in = io_sel ? io_rdata : mem_rdata;

endmodule

// File: tb/tb_bird_io_bridge.sv
// Self-checking bench for bird_io_bridge: directed scenarios plus randomized traffic
// against a queue-based behavioural model of the IO window and an external RAM model.
`timescale 1ns/1ps
module tb_bird_io_bridge;

  localparam int TXD = 8;

  logic        clk, rst;
  logic [15:0] cpu_address, cpu_data_out, cpu_data_in;
  logic        cpu_memwt;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_we;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid;

  bird_io_bridge dut (
    .clk(clk), .rst(rst),
    .cpu_address(cpu_address), .cpu_data_out(cpu_data_out), .cpu_memwt(cpu_memwt),
    .cpu_data_in(cpu_data_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External async-read RAM
  logic [15:0] ram [4096];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  // Behavioural model state
  logic [7:0] q[$];
  logic [7:0] m_rx_hold;
  bit         m_rx_full, m_tx_ovf, m_rx_ovr;

  int passed = 0;
  int total  = 0;

  logic [15:0] obs_din, exp_din;
  logic        obs_tv, exp_tv, obs_we, exp_we;
  logic [7:0]  obs_td, exp_td;

  function automatic bit m_io(input logic [15:0] a);
    return (a[11:8] == 4'hF) && (a[7:2] == 6'h00);
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    bit em, fu;
    em = (q.size() == 0);
    fu = (q.size() == TXD);
    if (!m_io(a)) return ram[a[11:0]];
    case (a[1:0])
      2'd0:    return 16'h0000;
      2'd1:    return {8'h00, m_rx_hold};
      2'd2:    return {11'b0, m_rx_ovr, m_tx_ovf, em, fu, m_rx_full};
      default: return 16'(q.size());
    endcase
  endfunction

  task automatic m_reset();
    q.delete();
    m_rx_hold = 8'h00;
    m_rx_full = 0;
    m_tx_ovf  = 0;
    m_rx_ovr  = 0;
  endtask

  task automatic m_tick(input logic [15:0] a, input logic [15:0] d, input bit we,
                        input bit rdy, input bit rxv, input logic [7:0] rxd);
    bit io, rxrd, set_txo, set_rxo;
    io = m_io(a);
    rxrd = io && !we && (a[1:0] == 2'd1);
    set_txo = 0;
    set_rxo = 0;
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (io && we && a[1:0] == 2'd0) begin
      if (q.size() < TXD) q.push_back(d[7:0]);
      else set_txo = 1;
    end
    if (io && we && a[1:0] == 2'd2) begin
      if (d[3]) m_tx_ovf = 0;
      if (d[4]) m_rx_ovr = 0;
    end
    if (rxv) begin
      if (!m_rx_full || rxrd) begin
        m_rx_hold = rxd;
        m_rx_full = 1;
      end else set_rxo = 1;
    end else if (rxrd) m_rx_full = 0;
    if (set_txo) m_tx_ovf = 1;
    if (set_rxo) m_rx_ovr = 1;
  endtask

  // One bus cycle: drive at negedge, capture outputs and model expectations, then clock.
  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input bit we,
                     input bit rdy, input bit rxv, input logic [7:0] rxd);
    @(negedge clk);
    cpu_address = a; cpu_data_out = d; cpu_memwt = we;
    tx_ready = rdy; rx_valid = rxv; rx_data = rxd;
    #1;
    obs_din = cpu_data_in; obs_tv = tx_valid; obs_td = tx_data; obs_we = mem_we;
    exp_din = m_read(a);
    exp_tv  = (q.size() != 0);
    exp_td  = (q.size() != 0) ? q[0] : 8'h00;
    exp_we  = we && !m_io(a);
    @(posedge clk);
    m_tick(a, d, we, rdy, rxv, rxd);
  endtask

  task automatic idle(input bit rdy);
    cyc(16'h0200, 16'h0000, 0, rdy, 0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_address = 16'h0050; cpu_data_out = 16'h1234; cpu_memwt = 1'b1;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #2;
    total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we); else passed++;
    total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data); else passed++;
    cpu_address = 16'h0F02; cpu_memwt = 1'b0;
    #1;
    total++; if (cpu_data_in !== 16'h0004) $display("FAIL reset_status: got %h expected 0004", cpu_data_in); else passed++;
    cpu_address = 16'h0F01;
    #1;
    total++; if (cpu_data_in !== 16'h0000) $display("FAIL reset_rxdata: got %h expected 0000", cpu_data_in); else passed++;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_ram();
    cyc(16'h0012, 16'hBEEF, 1, 0, 0, 8'h00);
    total++; if (obs_we !== 1'b1) $display("FAIL ram_we_on_write: got %b expected 1", obs_we); else passed++;
    cyc(16'h0012, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_we !== 1'b0) $display("FAIL ram_we_after: got %b expected 0", obs_we); else passed++;
    total++; if (obs_din !== 16'hBEEF) $display("FAIL ram_read: got %h expected BEEF", obs_din); else passed++;
    cyc(16'hA012, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din !== 16'hBEEF) $display("FAIL ram_alias_read: got %h expected BEEF", obs_din); else passed++;
  endtask

  task automatic test_tx_basic();
    cyc(16'h0F00, 16'h0041, 1, 0, 0, 8'h00);
    total++; if (obs_tv !== 1'b0) $display("FAIL tx_no_fallthrough: got %b expected 0", obs_tv); else passed++;
    cyc(16'h0F00, 16'h0042, 1, 0, 0, 8'h00);
    cyc(16'h0F03, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din !== 16'd2 || obs_din !== exp_din) $display("FAIL txcount_2: got %h expected %h", obs_din, exp_din); else passed++;
    total++; if (obs_td !== 8'h41) $display("FAIL tx_head_41: got %h expected 41", obs_td); else passed++;
    idle(1);
    total++; if (obs_td !== 8'h41 || obs_tv !== 1'b1) $display("FAIL tx_out_41: got %h/%b expected 41/1", obs_td, obs_tv); else passed++;
    idle(1);
    total++; if (obs_td !== 8'h42 || obs_tv !== 1'b1) $display("FAIL tx_out_42: got %h/%b expected 42/1", obs_td, obs_tv); else passed++;
    idle(0);
    total++; if (obs_tv !== 1'b0 || obs_td !== 8'h00) $display("FAIL tx_drained: got %b/%h expected 0/00", obs_tv, obs_td); else passed++;
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < TXD; i++) cyc(16'h0F00, 16'(8'h10 + i), 1, 0, 0, 8'h00);
    cyc(16'h0F00, 16'h0099, 1, 0, 0, 8'h00);
    cyc(16'h0F02, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din !== 16'h000A || obs_din !== exp_din) $display("FAIL tx_ovf_status: got %h expected %h", obs_din, exp_din); else passed++;
    cyc(16'h0F02, 16'h0008, 1, 0, 0, 8'h00);
    cyc(16'h0F00, 16'h00AB, 1, 1, 0, 8'h00);
    cyc(16'h0F02, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din !== 16'h0002 || obs_din !== exp_din) $display("FAIL tx_push_pop_full: got %h expected %h", obs_din, exp_din); else passed++;
    cyc(16'h0F03, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din !== 16'd8) $display("FAIL txcount_full: got %h expected 0008", obs_din); else passed++;
    for (int i = 0; i < TXD; i++) begin
      idle(1);
      total++; if (obs_td !== exp_td || obs_tv !== 1'b1) $display("FAIL tx_drain_order: got %h/%b expected %h/1", obs_td, obs_tv, exp_td); else passed++;
    end
    total++; if (exp_td !== 8'hAB) $display("FAIL tx_last_byte: got %h expected AB", exp_td); else passed++;
  endtask

  task automatic test_rx_overrun();
    cyc(16'h0200, 16'h0000, 0, 0, 1, 8'h55);
    cyc(16'h0200, 16'h0000, 0, 0, 1, 8'h66);
    cyc(16'h0F01, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din !== 16'h0055) $display("FAIL rx_keep_first: got %h expected 0055", obs_din); else passed++;
    cyc(16'h0F02, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din[4] !== 1'b1 || obs_din !== exp_din) $display("FAIL rx_ovr_set: got %h expected %h", obs_din, exp_din); else passed++;
    cyc(16'h0F02, 16'h0010, 1, 0, 0, 8'h00);
    cyc(16'h0F02, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din[4] !== 1'b0) $display("FAIL rx_ovr_w1c: got %h expected bit4=0", obs_din); else passed++;
  endtask

  task automatic test_rx_coincident();
    cyc(16'h0200, 16'h0000, 0, 0, 1, 8'h55);
    cyc(16'h0F01, 16'h0000, 0, 0, 1, 8'h77);
    total++; if (obs_din !== 16'h0055) $display("FAIL rx_coinc_old: got %h expected 0055", obs_din); else passed++;
    cyc(16'h0F01, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din !== 16'h0077) $display("FAIL rx_coinc_new: got %h expected 0077", obs_din); else passed++;
    cyc(16'h0F02, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din[4] !== 1'b0 || obs_din[0] !== 1'b0) $display("FAIL rx_coinc_status: got %h expected bit4=0 bit0=0", obs_din); else passed++;
    cyc(16'h0F01, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din !== 16'h0077) $display("FAIL rx_stale_read: got %h expected 0077", obs_din); else passed++;
    // Overflow coinciding with W1C must leave the flag set
    cyc(16'h0200, 16'h0000, 0, 0, 1, 8'hAA);
    cyc(16'h0F02, 16'h0010, 1, 0, 1, 8'hBB);
    cyc(16'h0F02, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din[4] !== 1'b1) $display("FAIL rx_ovr_set_wins: got %h expected bit4=1", obs_din); else passed++;
    cyc(16'h0F01, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din !== 16'h00AA) $display("FAIL rx_drop_keeps: got %h expected 00AA", obs_din); else passed++;
    cyc(16'h0F02, 16'h0018, 1, 0, 0, 8'h00);
  endtask

  task automatic test_random();
    logic [15:0] a, d;
    bit we, rdy, rxv;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) < 7) a = {4'($urandom), 10'h3C0, 2'($urandom)};
      else begin
        a = 16'($urandom);
        if (m_io(a)) a[11] = 1'b0;
      end
      d   = 16'($urandom);
      we  = ($urandom_range(2) != 0);
      rdy = ($urandom_range(3) == 0);
      rxv = ($urandom_range(2) == 0);
      cyc(a, d, we, rdy, rxv, 8'($urandom));
      total++; if (obs_din !== exp_din) $display("FAIL rnd_data_in[%0d] a=%h: got %h expected %h", i, a, obs_din, exp_din); else passed++;
      total++; if (obs_tv !== exp_tv || obs_td !== exp_td) $display("FAIL rnd_tx[%0d]: got %b/%h expected %b/%h", i, obs_tv, obs_td, exp_tv, exp_td); else passed++;
      total++; if (obs_we !== exp_we) $display("FAIL rnd_mem_we[%0d]: got %b expected %b", i, obs_we, exp_we); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    idle(1);
    cyc(16'h0F02, 16'h0018, 1, 1, 0, 8'h00);
    cyc(16'h0F01, 16'h0000, 0, 1, 0, 8'h00);
    while (q.size() != 0) idle(1);
    cyc(16'h0F00, 16'h0001, 1, 0, 0, 8'h00);
    cyc(16'h0F00, 16'h0002, 1, 0, 0, 8'h00);
    cyc(16'h0F00, 16'h0003, 1, 0, 0, 8'h00);
    cyc(16'h0200, 16'h0000, 0, 0, 1, 8'h5A);
    idle(1);
    @(negedge clk);
    cpu_address = 16'h0050; cpu_data_out = 16'hCAFE; cpu_memwt = 1'b1; tx_ready = 1'b1;
    #1;
    total++; if (tx_valid !== 1'b1 || mem_we !== 1'b1) $display("FAIL pre_rst: got %b/%b expected 1/1", tx_valid, mem_we); else passed++;
    rst = 1'b1;
    #1;
    total++; if (tx_valid !== 1'b0) $display("FAIL mid_rst_tx_valid: got %b expected 0", tx_valid); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL mid_rst_tx_data: got %h expected 00", tx_data); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL mid_rst_mem_we: got %b expected 0", mem_we); else passed++;
    cpu_address = 16'h0F02; cpu_memwt = 1'b0;
    #1;
    total++; if (cpu_data_in !== 16'h0004) $display("FAIL mid_rst_status: got %h expected 0004", cpu_data_in); else passed++;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    cyc(16'h0F03, 16'h0000, 0, 0, 0, 8'h00);
    total++; if (obs_din !== 16'h0000) $display("FAIL post_rst_count: got %h expected 0000", obs_din); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'(i * 7 + 3);
    test_reset();
    test_ram();
    test_tx_basic();
    test_tx_full();
    test_rx_overrun();
    test_rx_coincident();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
